// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the default word width / inter-word gap.
package serial_pattern_tx_pkg;

   localparam int WIDTH_DEFAULT = 8;
   localparam int GAP_DEFAULT   = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/serial_pattern_tx_piso_shift.sv
// Parallel-in serial-out shifter with a remaining-bit counter.
// The used field is left-aligned on load so bit_out is always the MSB of the
// register; the unused low bits are zero-filled, so after the last shift the
// register is all zeros and bit_out idles at 0 without extra gating.
// empty=1 means the bit currently on bit_out is the final one (or nothing
// was loaded).
module piso_shift #(
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LW-1:0]    load_len,
   input  logic             shift,
   output logic             bit_out,
   output logic             empty
);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [LW-1:0]    cnt_q, cnt_d;

   // Next-state for the shifter: load takes priority over shift.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load) begin
         sr_d  = load_data << (WIDTH - int'(load_len));
         cnt_d = (load_len == '0) ? '0 : load_len - LW'(1);
      end else if (shift) begin
         sr_d  = {sr_q[WIDTH-2:0], 1'b0};
         cnt_d = (cnt_q == '0) ? '0 : cnt_q - LW'(1);
      end
   end

   // Shift register and counter; reset clears any partial word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign bit_out = sr_q[WIDTH-1];
   assign empty   = (cnt_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a word plus a bit length, emits the
// used field MSB first on x with x_valid, pulses done after the last bit and
// then idles for GAP cycles before accepting the next word.
//
// Handshake: a word is accepted on a rising edge where in_valid=1 and
// in_ready=1. in_ready is registered and is high only in IDLE, so in_valid
// while busy is ignored and the source must hold the word until accepted.
module serial_pattern_tx
   import serial_pattern_tx_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int GAP   = GAP_DEFAULT,
   parameter int LW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LW-1:0]    in_len,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x,
   output logic             x_valid,
   output logic             done
);

   localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

   state_e         state_q, state_d;
   logic [GCW-1:0] gap_q, gap_d;
   logic           x_valid_q, x_valid_d;
   logic           done_q, done_d;
   logic           in_ready_q, in_ready_d;

   logic           hs;
   logic [LW-1:0]  len_eff;
   logic           load, shift, empty, bit_out;

   piso_shift #(
      .WIDTH (WIDTH),
      .LW    (LW)
   ) u_piso (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .load_data (in_data),
      .load_len  (len_eff),
      .shift     (shift),
      .bit_out   (bit_out),
      .empty     (empty)
   );

   // FSM next-state, gap counter and registered-output next values.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      load    = 1'b0;
      shift   = 1'b0;
      done_d  = 1'b0;
      hs      = in_valid & in_ready_q;
      len_eff = (in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
      case (state_q)
         S_IDLE: begin
            if (hs) begin
               load = 1'b1;
               if (len_eff != '0) begin
                  state_d = S_SHIFT;
               end else begin
                  // Zero-length word: consumed, completes at once, no gap.
                  done_d = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            // Always advance; the final shift leaves the register zeroed.
            shift = 1'b1;
            if (empty) begin
               done_d = 1'b1;
               if (GAP > 0) begin
                  state_d = S_GAP;
                  gap_d   = GAP_LAST;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - GCW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      x_valid_d  = (state_d == S_SHIFT);
      in_ready_d = (state_d == S_IDLE);
   end

   // State and output registers. in_ready resets low and rises on the first
   // edge after reset release, which also retimes the release internally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         gap_q      <= '0;
         x_valid_q  <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         x_valid_q  <= x_valid_d;
         done_q     <= done_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign x        = bit_out;
   assign x_valid  = x_valid_q;
   assign done     = done_q;
   assign in_ready = in_ready_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx (WIDTH=8, GAP=1): a cycle table of
// inputs and hand-computed outputs, plus a reset-during-shift sequence.
module tb_serial_pattern_tx;

   localparam int WIDTH = 8;
   localparam int GAP   = 1;
   localparam int LW    = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] in_data;
   logic [LW-1:0]    in_len;
   logic             in_valid;
   logic             in_ready;
   logic             x;
   logic             x_valid;
   logic             done;

   int n_vec  = 0;
   int n_miss = 0;

   // One table row: inputs held across an edge, outputs expected after it.
   // exp packs {x, x_valid, done, in_ready}.
   typedef struct {
      logic             vld;
      logic [WIDTH-1:0] data;
      logic [LW-1:0]    len;
      logic [3:0]       exp;
   } vec_t;

   vec_t vecs[$];

   serial_pattern_tx #(
      .WIDTH (WIDTH),
      .GAP   (GAP),
      .LW    (LW)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_data  (in_data),
      .in_len   (in_len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x        (x),
      .x_valid  (x_valid),
      .done     (done)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want summary");
      $fatal(1, "timeout");
   end

   function automatic void add(input logic v, input logic [WIDTH-1:0] d,
                               input logic [LW-1:0] l, input logic [3:0] e);
      vec_t t;
      t.vld  = v;
      t.data = d;
      t.len  = l;
      t.exp  = e;
      vecs.push_back(t);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] exp);
      logic [3:0] act;
      act = {x, x_valid, done, in_ready};
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: x/xv/done/rdy got %b want %b", name, act, exp);
      end
   endtask

   initial begin
      // Reset state
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_len   = '0;
      repeat (3) tick();
      check("reset_hold", 4'b0000);
      reset_n = 1'b1;

      // v0: first edge after release raises in_ready
      add(0, 8'h00, 4'd0,  4'b0001);
      // 8'h05 len 3 -> 1,0,1 then done, then idle
      add(1, 8'h05, 4'd3,  4'b1100);
      add(0, 8'h00, 4'd0,  4'b0100);
      add(0, 8'h00, 4'd0,  4'b1100);
      add(0, 8'h00, 4'd0,  4'b0010);
      add(0, 8'h00, 4'd0,  4'b0001);
      // 8'hA5 len 8 accepted; next word 8'h03 len 2 held valid while busy
      add(1, 8'hA5, 4'd8,  4'b1100);
      add(1, 8'h03, 4'd2,  4'b0100);
      add(1, 8'h03, 4'd2,  4'b1100);
      add(1, 8'h03, 4'd2,  4'b0100);
      add(1, 8'h03, 4'd2,  4'b0100);
      add(1, 8'h03, 4'd2,  4'b1100);
      add(1, 8'h03, 4'd2,  4'b0100);
      add(1, 8'h03, 4'd2,  4'b1100);
      add(1, 8'h03, 4'd2,  4'b0010);
      add(1, 8'h03, 4'd2,  4'b0001);
      add(1, 8'h03, 4'd2,  4'b1100);
      add(0, 8'h00, 4'd0,  4'b1100);
      add(0, 8'h00, 4'd0,  4'b0010);
      add(0, 8'h00, 4'd0,  4'b0001);
      // len 0: done next cycle, no bits, stays ready; then len 12 clamps to 8
      add(1, 8'hFF, 4'd0,  4'b0011);
      add(1, 8'hFF, 4'd12, 4'b1100);
      for (int i = 0; i < 7; i++) add(0, 8'h00, 4'd0, 4'b1100);
      add(0, 8'h00, 4'd0,  4'b0010);
      add(0, 8'h00, 4'd0,  4'b0001);
      // in_data changed mid-shift to 8'h02: output stays 1,0,1
      add(1, 8'h05, 4'd3,  4'b1100);
      add(0, 8'h02, 4'd3,  4'b0100);
      add(0, 8'h02, 4'd3,  4'b1100);
      add(0, 8'h02, 4'd3,  4'b0010);
      add(0, 8'h02, 4'd3,  4'b0001);
      // len 1 with a zero bit: x_valid=1 while x=0
      add(1, 8'hFE, 4'd1,  4'b0100);
      add(0, 8'h00, 4'd0,  4'b0010);
      add(0, 8'h00, 4'd0,  4'b0001);
      // len 0 directly followed by a full word 8'h80
      add(1, 8'h00, 4'd0,  4'b0011);
      add(1, 8'h80, 4'd8,  4'b1100);
      for (int i = 0; i < 7; i++) add(0, 8'h00, 4'd0, 4'b0100);
      add(0, 8'h00, 4'd0,  4'b0010);
      add(0, 8'h00, 4'd0,  4'b0001);

      foreach (vecs[i]) begin
         in_valid = vecs[i].vld;
         in_data  = vecs[i].data;
         in_len   = vecs[i].len;
         tick();
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Reset after the 4th bit of 8'hF0 len 8
      in_valid = 1'b1;
      in_data  = 8'hF0;
      in_len   = 4'd8;
      tick();
      check("f0_bit1", 4'b1100);
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_len   = 4'd0;
      tick();
      check("f0_bit2", 4'b1100);
      tick();
      check("f0_bit3", 4'b1100);
      tick();
      check("f0_bit4", 4'b1100);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_immediate", 4'b0000);
      tick();
      check("rst_held1", 4'b0000);
      tick();
      check("rst_held2", 4'b0000);
      reset_n = 1'b1;
      #1;
      check("rst_release_pre_edge", 4'b0000);
      tick();
      check("rst_release_ready", 4'b0001);
      tick();
      check("rst_no_replay1", 4'b0001);
      tick();
      check("rst_no_replay2", 4'b0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
